// File: rtl/game2048_pkg.sv
// Shared types for the 2048 board datapath: tile/board shapes, move direction
// and move-engine state encoding.
package game2048_pkg;

    localparam int unsigned TILE_W = 12;

    typedef logic [TILE_W-1:0] tile_t;
    typedef tile_t [3:0][3:0]  board_t;

    typedef enum logic [1:0] {DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN} dir_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mv_state_t;

    // Largest representable power of two; doubling it would overflow a tile.
    localparam tile_t TILE_MAX = tile_t'(1) << (TILE_W - 1);

endpackage

// File: rtl/move_engine_if.sv
// Request/result bundle between the game controller and the move engine.
interface move_engine_if;
    import game2048_pkg::*;

    logic        start;
    dir_t        dir;
    board_t      board_in;
    logic        busy;
    logic        done;
    board_t      board_out;
    logic        moved;
    logic [15:0] score_add;

    modport master (
        output start, dir, board_in,
        input  busy, done, board_out, moved, score_add
    );

    modport slave (
        input  start, dir, board_in,
        output busy, done, board_out, moved, score_add
    );

endinterface

// File: rtl/line_slide.sv
// Combinational slide-and-merge of one 4-tile line toward element 0.
module line_slide
    import game2048_pkg::*;
(
    input  tile_t       line_in  [4],
    output tile_t       line_out [4],
    output logic [15:0] gain,
    output logic        changed
);

    tile_t      packed_l [4];
    tile_t      merged   [4];
    logic [2:0] n_pack;
    logic [2:0] n_out;
    logic       skip;

    always_comb begin
        n_pack = '0;
        for (int i = 0; i < 4; i++) packed_l[i] = '0;
        for (int i = 0; i < 4; i++) begin
            if (line_in[i] != '0) begin
                packed_l[n_pack[1:0]] = line_in[i];
                n_pack = n_pack + 3'd1;
            end
        end

        // A merged tile leaves a hole behind it so it cannot merge again.
        gain = '0;
        skip = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (skip) begin
                merged[i] = '0;
                skip      = 1'b0;
            end else if (packed_l[i] != '0 && packed_l[i] == packed_l[i+1] &&
                         packed_l[i] != TILE_MAX) begin
                merged[i] = packed_l[i] << 1;
                gain      = gain + (16'(packed_l[i]) << 1);
                skip      = 1'b1;
            end else begin
                merged[i] = packed_l[i];
            end
        end
        merged[3] = skip ? '0 : packed_l[3];

        n_out = '0;
        for (int i = 0; i < 4; i++) line_out[i] = '0;
        for (int i = 0; i < 4; i++) begin
            if (merged[i] != '0) begin
                line_out[n_out[1:0]] = merged[i];
                n_out = n_out + 3'd1;
            end
        end

        changed = 1'b0;
        for (int i = 0; i < 4; i++) changed = changed | (line_out[i] != line_in[i]);
    end

endmodule

// File: rtl/move_engine.sv
// Applies one 2048 move to a 4x4 board, one row or column per clock, and
// reports score gain and whether anything moved.
module move_engine
    import game2048_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    move_engine_if.slave bus
);

    mv_state_t   state_q;
    board_t      board_q;
    board_t      orig_q;
    dir_t        dir_q;
    logic [1:0]  line_idx_q;
    logic [15:0] score_q;
    logic        moved_q;
    logic        done_q;

    tile_t       line_in  [4];
    tile_t       line_out [4];
    logic [15:0] gain;
    logic        changed;
    board_t      board_wr;

    // Lines are disjoint, so the captured board still holds each line's input.
    always_comb begin
        for (int e = 0; e < 4; e++) begin
            line_in[e] = '0;
            unique case (dir_q)
                DIR_LEFT:  line_in[e] = orig_q[line_idx_q][e];
                DIR_RIGHT: line_in[e] = orig_q[line_idx_q][3-e];
                DIR_UP:    line_in[e] = orig_q[e][line_idx_q];
                DIR_DOWN:  line_in[e] = orig_q[3-e][line_idx_q];
                default:   line_in[e] = '0;
            endcase
        end
    end

    line_slide u_line_slide (
        .line_in  (line_in),
        .line_out (line_out),
        .gain     (gain),
        .changed  (changed)
    );

    always_comb begin
        board_wr = board_q;
        for (int e = 0; e < 4; e++) begin
            unique case (dir_q)
                DIR_LEFT:  board_wr[line_idx_q][e]   = line_out[e];
                DIR_RIGHT: board_wr[line_idx_q][3-e] = line_out[e];
                DIR_UP:    board_wr[e][line_idx_q]   = line_out[e];
                DIR_DOWN:  board_wr[3-e][line_idx_q] = line_out[e];
                default:   board_wr = board_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            board_q    <= '0;
            orig_q     <= '0;
            dir_q      <= DIR_LEFT;
            line_idx_q <= '0;
            score_q    <= '0;
            moved_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        board_q    <= bus.board_in;
                        orig_q     <= bus.board_in;
                        dir_q      <= bus.dir;
                        score_q    <= '0;
                        moved_q    <= 1'b0;
                        line_idx_q <= '0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    board_q    <= board_wr;
                    score_q    <= score_q + gain;
                    moved_q    <= moved_q | changed;
                    line_idx_q <= line_idx_q + 2'd1;
                    if (line_idx_q == 2'd3) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.board_out = board_q;
    assign bus.moved     = moved_q;
    assign bus.score_add = score_q;

endmodule

// File: tb/tb_move_engine.sv
// Self-checking bench for move_engine: directed corner cases plus random moves
// compared against a queue-based reference of the 2048 slide rules.
module tb_move_engine;
    import game2048_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    move_engine_if bus ();

    move_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: take non-zero tiles, merge equal neighbours left to right once each.
    function automatic void ref_line(input int v[4], output int o[4], inout int gain);
        int q[$];
        int r[$];
        int i;
        for (int k = 0; k < 4; k++) if (v[k] != 0) q.push_back(v[k]);
        i = 0;
        while (i < q.size()) begin
            if (i + 1 < q.size() && q[i] == q[i+1] && q[i] != 2048) begin
                r.push_back(q[i] * 2);
                gain += q[i] * 2;
                i += 2;
            end else begin
                r.push_back(q[i]);
                i += 1;
            end
        end
        for (int k = 0; k < 4; k++) o[k] = (k < r.size()) ? r[k] : 0;
    endfunction

    function automatic void ref_move(input board_t b, input dir_t d, output board_t res,
                                     output int gain);
        int v[4];
        int o[4];
        res  = b;
        gain = 0;
        for (int k = 0; k < 4; k++) begin
            for (int e = 0; e < 4; e++) begin
                case (d)
                    DIR_LEFT:  v[e] = int'(b[k][e]);
                    DIR_RIGHT: v[e] = int'(b[k][3-e]);
                    DIR_UP:    v[e] = int'(b[e][k]);
                    default:   v[e] = int'(b[3-e][k]);
                endcase
            end
            ref_line(v, o, gain);
            for (int e = 0; e < 4; e++) begin
                case (d)
                    DIR_LEFT:  res[k][e]   = tile_t'(o[e]);
                    DIR_RIGHT: res[k][3-e] = tile_t'(o[e]);
                    DIR_UP:    res[e][k]   = tile_t'(o[e]);
                    default:   res[3-e][k] = tile_t'(o[e]);
                endcase
            end
        end
    endfunction

    function automatic tile_t rtile();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 4) return '0;
        if (r < 8) return tile_t'(2 << $urandom_range(0, 2));
        return tile_t'(1 << $urandom_range(1, 11));
    endfunction

    function automatic board_t rboard();
        board_t b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) b[r][c] = rtile();
        return b;
    endfunction

    // Start a move, scramble inputs while busy, check latency and results.
    task automatic do_move(input string tag, input board_t b, input dir_t d);
        board_t exp_b;
        int     exp_g;
        int     n;
        bit     seen;
        ref_move(b, d, exp_b, exp_g);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dir      = d;
        bus.board_in = b;
        n    = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            bus.start    = 1'b0;
            bus.dir      = dir_t'($urandom_range(0, 3));
            bus.board_in = rboard();
            if (bus.done) seen = 1'b1;
        end
        check({tag, "/latency"}, 192'(n), 192'(5));
        check({tag, "/busy_done"}, 192'(bus.busy), 192'(1));
        check({tag, "/board"}, 192'(bus.board_out), 192'(exp_b));
        check({tag, "/score"}, 192'(bus.score_add), 192'(exp_g));
        check({tag, "/moved"}, 192'(bus.moved), 192'(exp_b != b));
        @(negedge clk);
        check({tag, "/idle"}, 192'({bus.busy, bus.done}), 192'(0));
        check({tag, "/hold"}, 192'(bus.board_out), 192'(exp_b));
    endtask

    initial begin
        board_t b;
        board_t exp_b;
        int     exp_g;
        int     dones;
        int     first_done;
        int     second_done;

        bus.start    = 1'b0;
        bus.dir      = DIR_LEFT;
        bus.board_in = '0;

        #1;
        check("reset/outs", 192'({bus.busy, bus.done, bus.moved, bus.score_add}), 192'(0));
        check("reset/board", 192'(bus.board_out), 192'(0));
        @(negedge clk);
        rst_n = 1'b1;

        b = '0;
        b[0][0] = 2; b[0][1] = 2; b[0][2] = 2; b[0][3] = 2;
        do_move("t1_2222_left", b, DIR_LEFT);

        b = '0;
        b[1][0] = 2; b[2][0] = 2; b[3][0] = 4;
        do_move("t2_col_down", b, DIR_DOWN);

        b = '0;
        b[0][0] = 2; b[0][1] = 4; b[0][2] = 2; b[0][3] = 4;
        b[1][0] = 8; b[1][1] = 16;
        b[2][0] = 32;
        do_move("t3_packed", b, DIR_LEFT);

        b = '0;
        b[0][0] = 2048; b[0][1] = 2048;
        do_move("t4_max_tile", b, DIR_LEFT);

        b = '0;
        b[0][0] = 4; b[0][1] = 4; b[0][2] = 8;
        do_move("t4b_4480", b, DIR_LEFT);

        // Second start at E2 with a different direction must be ignored.
        b = '0;
        b[0][0] = 2; b[0][1] = 2; b[1][0] = 2; b[2][1] = 4;
        ref_move(b, DIR_LEFT, exp_b, exp_g);
        @(negedge clk);
        bus.start = 1'b1; bus.dir = DIR_LEFT; bus.board_in = b;
        dones = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            bus.start = (n == 2);
            if (n == 2) bus.dir = DIR_UP;
            if (bus.done) begin
                dones++;
                check("t5/busy_done", 192'(bus.busy), 192'(1));
                check("t5/board", 192'(bus.board_out), 192'(exp_b));
                check("t5/score", 192'(bus.score_add), 192'(exp_g));
            end
        end
        check("t5/done_count", 192'(dones), 192'(1));

        // Reset during RUN clears everything at once and flags no done.
        b = rboard();
        @(negedge clk);
        bus.start = 1'b1; bus.dir = DIR_RIGHT; bus.board_in = b;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6/outs", 192'({bus.busy, bus.done, bus.moved, bus.score_add}), 192'(0));
        check("t6/board", 192'(bus.board_out), 192'(0));
        dones = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("t6/no_done", 192'(dones), 192'(0));
        rst_n = 1'b1;
        do_move("t6_after_reset", b, DIR_RIGHT);

        // start held high: next move begins one cycle after DONE.
        b = rboard();
        @(negedge clk);
        bus.start = 1'b1; bus.dir = DIR_UP; bus.board_in = b;
        first_done  = 0;
        second_done = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (bus.done) begin
                if (first_done == 0) first_done = n;
                else if (second_done == 0) second_done = n;
            end
        end
        bus.start = 1'b0;
        check("t7/first_done", 192'(first_done), 192'(5));
        check("t7/retrigger", 192'(second_done), 192'(11));
        repeat (3) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            do_move($sformatf("rand%0d", i), rboard(), dir_t'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
